bsg_id_pool_multi: RTL

Multi-client ID pool with per-ID metadata storage ("coatcheck") and per-client outstanding quotas. Up to `num_clients_p` requestors compete for one of `els_p` IDs per cycle under round-robin arbitration; each allocation stores a metadata word, which is returned together with the owning client on deallocation. It sits between request-issuing clients and an out-of-order response path, replacing single-client ID pools where responses must be steered back to their originator.

---
 rtl/bsg_id_pool_multi.sv | 138 +++++++++++++
 1 files changed

// File: rtl/bsg_id_pool_multi.sv
// Multi-client ID pool with per-ID metadata and owner storage ("coatcheck").
// Round-robin grant among quota-eligible clients; deallocation returns metadata and owner one cycle later.
module bsg_id_pool_multi #(
  parameter int els_p           = 4,
  parameter int num_clients_p   = 2,
  parameter int data_width_p    = 8,
  parameter int quota_p         = els_p,
  parameter int id_width_lp     = (els_p > 1) ? $clog2(els_p) : 1,
  parameter int client_width_lp = (num_clients_p > 1) ? $clog2(num_clients_p) : 1
) (
  input  logic                                    clk_i,
  input  logic                                    reset_n_i,
  input  logic [num_clients_p-1:0]                alloc_v_i,
  input  logic [num_clients_p*data_width_p-1:0]   alloc_data_i,
  output logic [num_clients_p-1:0]                alloc_yumi_o,
  output logic [id_width_lp-1:0]                  alloc_id_o,
  input  logic                                    dealloc_v_i,
  input  logic [id_width_lp-1:0]                  dealloc_id_i,
  output logic                                    dealloc_v_o,
  output logic [data_width_p-1:0]                 dealloc_data_o,
  output logic [client_width_lp-1:0]              dealloc_client_o,
  output logic [$clog2(els_p+1)-1:0]              free_count_o,
  output logic                                    error_o
);

  localparam int count_w_lp = $clog2(quota_p + 1);
  localparam int fc_w_lp    = $clog2(els_p + 1);

  logic [els_p-1:0]           free_r;
  logic [client_width_lp-1:0] owner_r [els_p];
  logic [data_width_p-1:0]    meta_r  [els_p];
  logic [count_w_lp-1:0]      count_r [num_clients_p];
  logic [client_width_lp-1:0] rr_r;

  logic [num_clients_p-1:0]   eligible;
  logic [num_clients_p-1:0]   inc;
  logic [num_clients_p-1:0]   dec;
  logic [client_width_lp-1:0] winner;
  logic [client_width_lp-1:0] cand;
  logic [data_width_p-1:0]    win_data;
  logic                       have_winner;
  logic                       any_free;
  logic                       grant;
  logic                       dealloc_ok;

  function automatic logic [client_width_lp-1:0] rr_next(
    input logic [client_width_lp-1:0] base,
    input int                         offset
  );
    int s;
    s = int'(base) + offset;
    if (s >= num_clients_p) s = s - num_clients_p;
    return client_width_lp'(s);
  endfunction

  // Arbitration: first eligible client at/after the RR pointer, lowest free ID.
  always_comb begin
    eligible    = '0;
    winner      = '0;
    cand        = '0;
    have_winner = 1'b0;
    any_free    = 1'b0;
    alloc_id_o  = '0;
    win_data    = '0;
    for (int c = 0; c < num_clients_p; c++)
      eligible[c] = alloc_v_i[c] && (count_r[c] < count_w_lp'(quota_p));
    for (int i = 0; i < num_clients_p; i++) begin
      cand = rr_next(rr_r, i);
      if (!have_winner && eligible[cand]) begin
        have_winner = 1'b1;
        winner      = cand;
      end
    end
    for (int i = 0; i < els_p; i++) begin
      if (!any_free && free_r[i]) begin
        any_free   = 1'b1;
        alloc_id_o = id_width_lp'(i);
      end
    end
    for (int c = 0; c < num_clients_p; c++)
      if (winner == client_width_lp'(c))
        win_data = alloc_data_i[c*data_width_p +: data_width_p];
  end

  assign grant      = reset_n_i && have_winner && any_free;
  assign dealloc_ok = dealloc_v_i && (int'(dealloc_id_i) < els_p) && !free_r[dealloc_id_i];

  always_comb begin
    alloc_yumi_o         = '0;
    alloc_yumi_o[winner] = grant;
    inc = '0;
    dec = '0;
    for (int c = 0; c < num_clients_p; c++) begin
      inc[c] = grant && (winner == client_width_lp'(c));
      dec[c] = dealloc_ok && (owner_r[dealloc_id_i] == client_width_lp'(c));
    end
  end

  // Control state and registered return path
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      free_r           <= '1;
      rr_r             <= '0;
      dealloc_v_o      <= 1'b0;
      dealloc_data_o   <= '0;
      dealloc_client_o <= '0;
      free_count_o     <= fc_w_lp'(els_p);
      error_o          <= 1'b0;
      for (int c = 0; c < num_clients_p; c++) count_r[c] <= '0;
    end else begin
      if (grant) begin
        free_r[alloc_id_o] <= 1'b0;
        rr_r               <= rr_next(winner, 1);
      end
      if (dealloc_ok) begin
        free_r[dealloc_id_i] <= 1'b1;
        dealloc_data_o       <= meta_r[dealloc_id_i];
        dealloc_client_o     <= owner_r[dealloc_id_i];
      end
      dealloc_v_o  <= dealloc_ok;
      free_count_o <= free_count_o + fc_w_lp'(dealloc_ok) - fc_w_lp'(grant);
      error_o      <= error_o | (dealloc_v_i && !dealloc_ok);
      for (int c = 0; c < num_clients_p; c++) begin
        if (inc[c] && !dec[c])      count_r[c] <= count_r[c] + count_w_lp'(1);
        else if (dec[c] && !inc[c]) count_r[c] <= count_r[c] - count_w_lp'(1);
      end
    end
  end

  // Per-ID storage is only meaningful while the ID is busy, so it carries no reset.
  always_ff @(posedge clk_i) begin
    if (grant) begin
      meta_r[alloc_id_o]  <= win_data;
      owner_r[alloc_id_o] <= winner;
    end
  end

endmodule
